// File: rtl/sd_req_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : sd_req_arb_if
// Description : Sector-request bus between a requester and a sector server.
//               The master drives the request and the write-data byte. The
//               slave returns the ack and the buffer write strobe.
// Revision    : 1.0 - initial release
// ============================================================================
interface sd_req_arb_if;
  logic [31:0] lba;       // sector address
  logic        rd;        // read request (level)
  logic        wr;        // write request (level)
  logic        ack;       // request acknowledged / transfer in progress
  logic        buff_wr;   // buffer write strobe (sector data for reads)
  logic [7:0]  buff_din;  // buffer read data (sector data for writes)

  // Requester side: issues requests and supplies write data.
  modport master (
    output lba, rd, wr, buff_din,
    input  ack, buff_wr
  );

  // Server side: accepts requests and returns ack and strobes.
  modport slave (
    input  lba, rd, wr, buff_din,
    output ack, buff_wr
  );
endinterface
`default_nettype wire

// File: rtl/sd_req_arb.sv
`default_nettype none
// ============================================================================
// Module      : sd_req_arb
// Description : Round-robin arbiter sharing one IO-controller sector
//               interface between two requesters (A and B). It latches one
//               request, routes ack and buffer traffic to the granted port
//               only, and aborts a request the controller never acks.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_req_arb #(
  parameter int TIMEOUT_W = 24
) (
  input  wire logic      clk_sys,
  input  wire logic      reset,
  sd_req_arb_if.slave    a,
  sd_req_arb_if.slave    b,
  sd_req_arb_if.master   sd,
  output logic           busy,
  output logic           grant,
  output logic           timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          lba_q, lba_d;
  logic                 rd_q, rd_d;
  logic                 wr_q, wr_d;
  logic                 grant_q, grant_d;
  logic                 prio_q, prio_d;     // 0 = A has priority, 1 = B
  logic                 timeout_q, timeout_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;

  logic                 a_pend, b_pend, pick_b, sel_wr;
  logic                 gnt_rd, gnt_wr;
  logic [TIMEOUT_W-1:0] wd_inc;
  logic                 active;
  logic                 a_ack_w, b_ack_w;

  // Next-state logic: grant selection, request launch, watchdog, release.
  always_comb begin
    a_pend    = a.rd | a.wr;
    b_pend    = b.rd | b.wr;
    pick_b    = b_pend & (~a_pend | prio_q);
    sel_wr    = pick_b ? b.wr : a.wr;            // write wins over read
    gnt_rd    = grant_q ? b.rd : a.rd;
    gnt_wr    = grant_q ? b.wr : a.wr;
    wd_inc    = wd_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    state_d   = state_q;
    lba_d     = lba_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    grant_d   = grant_q;
    prio_d    = prio_q;
    timeout_d = 1'b0;
    wd_d      = wd_q;

    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (a_pend | b_pend) begin
          grant_d = pick_b;
          lba_d   = pick_b ? b.lba : a.lba;
          wr_d    = sel_wr;
          rd_d    = ~sel_wr;
          state_d = REQ;
        end
      end
      REQ: begin
        if (sd.ack) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          wd_d    = '0;
          state_d = XFER;
        end else if (&wd_inc) begin
          // Controller never answered: drop the request and let the
          // requester withdraw on its own before re-arbitrating.
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          wd_d      = '0;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          wd_d = wd_inc;
        end
      end
      XFER: begin
        if (!sd.ack) state_d = DONE;
      end
      DONE: begin
        // Hold off until the served port drops its level request so the
        // same request is not issued twice.
        if (!gnt_rd && !gnt_wr) begin
          prio_d  = ~grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= IDLE;
      lba_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      grant_q   <= 1'b0;
      prio_q    <= 1'b0;
      timeout_q <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      lba_q     <= lba_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      grant_q   <= grant_d;
      prio_q    <= prio_d;
      timeout_q <= timeout_d;
      wd_q      <= wd_d;
    end
  end

  // Ack and strobe routing stays combinational so each requester keeps its
  // own ack synchroniser timing; spurious acks outside REQ/XFER are dropped.
  assign active     = (state_q == REQ) || (state_q == XFER);
  assign a_ack_w    = sd.ack & active & ~grant_q;
  assign b_ack_w    = sd.ack & active &  grant_q;
  assign a.ack      = a_ack_w;
  assign b.ack      = b_ack_w;
  assign a.buff_wr  = sd.buff_wr & a_ack_w;
  assign b.buff_wr  = sd.buff_wr & b_ack_w;

  assign sd.lba      = lba_q;
  assign sd.rd       = rd_q;
  assign sd.wr       = wr_q;
  assign sd.buff_din = grant_q ? b.buff_din : a.buff_din;

  assign busy    = (state_q != IDLE);
  assign grant   = grant_q;
  assign timeout = timeout_q;

endmodule
`default_nettype wire
